// File: rtl/connect_four_renderer.sv
// Connect Four VGA renderer: board, cursor, falling-piece animation and win blinking.
// Latency: 2 cycles h/v/sync in -> colour/sync out; board read address issued in S0, data consumed in S1.
// Backpressure: none, free-running pixel stream; drop requests arriving while busy are discarded.
module connect_four_renderer #(
    parameter int ROWS         = 6,
    parameter int COLS         = 7,
    parameter int CELL_SHIFT   = 5,
    parameter int ORIGIN_X     = 208,
    parameter int ORIGIN_Y     = 144,
    parameter int CURSOR_GAP   = 16,
    parameter int RADIUS       = 14,
    parameter int FALL_STEP    = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [2:0] row_read,
    output logic [2:0] col_read,
    input  logic [1:0] cell_data,
    input  logic       win_cell,
    input  logic [2:0] current_col,
    input  logic [1:0] current_player,
    input  logic       game_over,
    input  logic       drop_start,
    input  logic [2:0] drop_col,
    input  logic [2:0] drop_row,
    output logic       anim_busy,
    output logic       anim_done,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b
);
    localparam int CELL = 1 << CELL_SHIFT;
    localparam int HALF = CELL / 2;
    localparam int DW   = 2 * CELL_SHIFT + 1;
    localparam int BW   = $clog2(BLINK_FRAMES) + 1;

    localparam logic [9:0]    CELL_W  = 10'(CELL);
    localparam logic [9:0]    BOARD_W = 10'(COLS << CELL_SHIFT);
    localparam logic [9:0]    BOARD_H = 10'(ROWS << CELL_SHIFT);
    localparam logic [9:0]    ORG_X   = 10'(ORIGIN_X);
    localparam logic [9:0]    ORG_Y   = 10'(ORIGIN_Y);
    localparam logic [9:0]    CUR_TOP = 10'(ORIGIN_Y - CURSOR_GAP - CELL);
    localparam logic [DW-1:0] R2      = DW'(RADIUS * RADIUS);

    localparam logic [5:0] C_BLACK = 6'b00_00_00;
    localparam logic [5:0] C_BG    = 6'b01_11_01;
    localparam logic [5:0] C_BLUE  = 6'b00_00_11;
    localparam logic [5:0] C_P1    = 6'b11_11_00;
    localparam logic [5:0] C_P2    = 6'b11_00_00;
    localparam logic [5:0] C_WHITE = 6'b11_11_11;

    typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;

    // Distance from cell centre; |offset - half| never exceeds HALF so it fits CELL_SHIFT bits.
    function automatic logic in_circle(input logic [CELL_SHIFT-1:0] lx,
                                       input logic [CELL_SHIFT-1:0] ly);
        logic [CELL_SHIFT-1:0] ax;
        logic [CELL_SHIFT-1:0] ay;
        logic [DW-1:0]         d2;
        ax = (lx >= CELL_SHIFT'(HALF)) ? lx - CELL_SHIFT'(HALF) : CELL_SHIFT'(HALF) - lx;
        ay = (ly >= CELL_SHIFT'(HALF)) ? ly - CELL_SHIFT'(HALF) : CELL_SHIFT'(HALF) - ly;
        d2 = DW'(ax) * DW'(ax) + DW'(ay) * DW'(ay);
        return d2 <= R2;
    endfunction

    function automatic logic [5:0] player_colour(input logic [1:0] p);
        case (p)
            2'b01:   return C_P1;
            2'b10:   return C_P2;
            default: return C_BG;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [9:0]      anim_y, anim_y_d, fall_y;
    logic [9:0]      anim_x_lo, tgt_top;
    logic [2:0]      tgt_row, tgt_col;
    logic [1:0]      anim_player;
    logic            load, done_d, drop_ok, frame_tick;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;

    // S0: address generation and region classification
    logic [9:0] ox, oy, ax_off, ay_off, cx_off, cy_off;
    logic       s0_active, s0_board, s0_board_circ, s0_anim, s0_cursor, s0_masked;

    assign ox       = h_count - ORG_X;
    assign oy       = v_count - ORG_Y;
    assign col_read = ox[CELL_SHIFT +: 3];
    assign row_read = 3'(ROWS - 1) - oy[CELL_SHIFT +: 3];
    assign ax_off   = h_count - anim_x_lo;
    assign ay_off   = v_count - anim_y;
    assign cx_off   = h_count - (ORG_X + (10'(current_col) << CELL_SHIFT));
    assign cy_off   = v_count - CUR_TOP;

    assign s0_active     = (h_count < 10'd640) && (v_count < 10'd480);
    assign s0_board      = (ox < BOARD_W) && (oy < BOARD_H);
    assign s0_board_circ = in_circle(ox[CELL_SHIFT-1:0], oy[CELL_SHIFT-1:0]);
    assign s0_anim       = (state_q != IDLE) && (ax_off < CELL_W) && (ay_off < CELL_W) &&
                           in_circle(ax_off[CELL_SHIFT-1:0], ay_off[CELL_SHIFT-1:0]);
    assign s0_cursor     = (state_q == IDLE) && !game_over && (cx_off < CELL_W) &&
                           (cy_off < CELL_W) && in_circle(cx_off[CELL_SHIFT-1:0], cy_off[CELL_SHIFT-1:0]);
    assign s0_masked     = (state_q == FALL) && (row_read == tgt_row) && (col_read == tgt_col);

    logic s1_active, s1_board, s1_board_circ, s1_anim, s1_cursor, s1_masked, s1_hs, s1_vs;
    logic [5:0] s2_colour;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            {s1_active, s1_board, s1_board_circ, s1_anim, s1_cursor, s1_masked} <= '0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            {vga_r, vga_g, vga_b} <= C_BLACK;
        end else begin
            s1_active     <= s0_active;
            s1_board      <= s0_board;
            s1_board_circ <= s0_board_circ;
            s1_anim       <= s0_anim;
            s1_cursor     <= s0_cursor;
            s1_masked     <= s0_masked;
            s1_hs         <= hsync_in;
            s1_vs         <= vsync_in;
            vga_hsync     <= s1_hs;
            vga_vsync     <= s1_vs;
            {vga_r, vga_g, vga_b} <= s2_colour;
        end
    end

    // S2: colour priority, cell_data/win_cell line up with the S1 registers
    always_comb begin
        s2_colour = C_BG;
        if (!s1_active)
            s2_colour = C_BLACK;
        else if (s1_anim)
            s2_colour = player_colour(anim_player);
        else if (s1_board && s1_board_circ) begin
            if (s1_masked || (cell_data != 2'b01 && cell_data != 2'b10))
                s2_colour = C_BG;
            else if (win_cell && blink_phase)
                s2_colour = C_WHITE;
            else
                s2_colour = player_colour(cell_data);
        end else if (s1_board)
            s2_colour = C_BLUE;
        else if (s1_cursor)
            s2_colour = player_colour(current_player);
    end

    assign frame_tick = (h_count == 10'd0) && (v_count == 10'd480);
    assign drop_ok    = (int'(drop_row) < ROWS) && (int'(drop_col) < COLS);
    assign anim_busy  = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        anim_y_d = anim_y;
        load     = 1'b0;
        done_d   = 1'b0;
        fall_y   = anim_y + 10'(FALL_STEP);
        case (state_q)
            IDLE: if (drop_start && drop_ok) begin
                load     = 1'b1;
                anim_y_d = CUR_TOP;
                state_d  = FALL;
            end
            FALL: if (frame_tick) begin
                if (fall_y >= tgt_top) begin
                    anim_y_d = tgt_top;
                    state_d  = LAND;
                end else begin
                    anim_y_d = fall_y;
                end
            end
            LAND: if (frame_tick) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            anim_y      <= '0;
            anim_x_lo   <= '0;
            tgt_top     <= '0;
            tgt_row     <= '0;
            tgt_col     <= '0;
            anim_player <= '0;
            anim_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            anim_y    <= anim_y_d;
            anim_done <= done_d;
            if (load) begin
                tgt_row     <= drop_row;
                tgt_col     <= drop_col;
                anim_player <= current_player;
                anim_x_lo   <= ORG_X + (10'(drop_col) << CELL_SHIFT);
                tgt_top     <= ORG_Y + (10'(3'(ROWS - 1) - drop_row) << CELL_SHIFT);
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!game_over) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
endmodule
